// File: rtl/rf_wb_pkg.sv
// Shared types and sizes for the register-file write-back sequencer.
package rf_wb_pkg;

  localparam int DW   = 8;
  localparam int AW   = 2;
  localparam int NREG = 1 << AW;

  typedef struct packed {
    logic [AW-1:0] dst;
    logic [DW-1:0] data;
  } wb_req_t;

  typedef struct packed {
    logic          v;
    logic [AW-1:0] dst;
  } ld_stage_t;

endpackage

// File: rtl/rf_writeback_if.sv
// Request/write-port bundle between decode, memory and rf_writeback.
// Optional forwarding signals exist only when RF_WB_FWD_EN is defined.
interface rf_writeback_if;
  import rf_wb_pkg::*;

  logic            alu_valid;
  logic [AW-1:0]   alu_dst;
  logic [DW-1:0]   alu_data;
  logic            ld_valid;
  logic [AW-1:0]   ld_dst;
  logic [DW-1:0]   mem_rdata;
  logic            stall;
  logic [NREG-1:0] busy;
  logic            rf_we;
  logic [AW-1:0]   rf_ptr_w;
  logic [DW-1:0]   rf_di;
`ifdef RF_WB_FWD_EN
  logic [AW-1:0]   fwd_ptr;
  logic            fwd_hit;
  logic [DW-1:0]   fwd_data;
`endif

  modport master (
    output alu_valid, alu_dst, alu_data,
    output ld_valid, ld_dst, mem_rdata,
`ifdef RF_WB_FWD_EN
    output fwd_ptr,
    input  fwd_hit, fwd_data,
`endif
    input  stall, busy,
    input  rf_we, rf_ptr_w, rf_di
  );

  modport slave (
    input  alu_valid, alu_dst, alu_data,
    input  ld_valid, ld_dst, mem_rdata,
`ifdef RF_WB_FWD_EN
    input  fwd_ptr,
    output fwd_hit, fwd_data,
`endif
    output stall, busy,
    output rf_we, rf_ptr_w, rf_di
  );

endinterface

// File: rtl/wb_fifo.sv
// Holding FIFO for ALU results; entries are exported oldest-first.
module wb_fifo
  import rf_wb_pkg::*;
#(
  parameter int QDEPTH = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  wb_req_t           din,
  input  logic              pop,
  output logic              full,
  output logic              empty,
  output wb_req_t           ents [QDEPTH],
  output logic [QDEPTH-1:0] vld
);

  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW = $clog2(QDEPTH + 1);

  wb_req_t       mem [QDEPTH];
  logic [PW-1:0] rp;
  logic [PW-1:0] wp;
  logic [CW-1:0] cnt;
  logic          wr;
  logic          rd;

  function automatic logic [PW-1:0] inc(
    input logic [PW-1:0] p
  );
    return (p == PW'(QDEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full  = cnt == CW'(QDEPTH);
  assign empty = cnt == '0;
  assign wr    = push & ~full;
  assign rd    = pop & ~empty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rp  <= '0;
      wp  <= '0;
      cnt <= '0;
    end else begin
      if (wr) wp <= inc(wp);
      if (rd) rp <= inc(rp);
      cnt <= cnt + CW'(wr) - CW'(rd);
    end
  end

  always_ff @(posedge clk) begin
    if (wr) mem[wp] <= din;
  end

  // slot k holds the k-th oldest entry
  always_comb begin
    for (int k = 0; k < QDEPTH; k++) begin
      ents[k] = mem[PW'((int'(rp) + k) % QDEPTH)];
      vld[k]  = k < int'(cnt);
    end
  end

endmodule

// File: rtl/rf_writeback.sv
// Register-file write sequencer: load pipe, ALU holding FIFO, hazards.
// Define RF_WB_FWD_EN to add FIFO forwarding (fwd_ptr/fwd_hit/fwd_data).
module rf_writeback
  import rf_wb_pkg::*;
#(
  parameter int LD_LAT = 2,
  parameter int QDEPTH = 2
) (
  input logic           clk,
  input logic           reset,
  rf_writeback_if.slave bus
);

  ld_stage_t         pipe [LD_LAT];
  ld_stage_t         ret;
  wb_req_t           q_ents [QDEPTH];
  logic [QDEPTH-1:0] q_vld;
  logic              q_full;
  logic              q_empty;
  logic              q_push;
  logic              q_pop;
  logic              acc_alu;
  logic              acc_ld;
  logic              ld_hit_q;
  logic              alu_hit_ld;
  logic [NREG-1:0]   busy_ld;
  logic [NREG-1:0]   busy_q;

  wb_fifo #(
    .QDEPTH(QDEPTH)
  ) u_fifo (
    .clk  (clk),
    .reset(reset),
    .push (q_push),
    .din  ({bus.alu_dst, bus.alu_data}),
    .pop  (q_pop),
    .full (q_full),
    .empty(q_empty),
    .ents (q_ents),
    .vld  (q_vld)
  );

  assign ret = pipe[LD_LAT-1];

  always_comb begin
    alu_hit_ld = 1'b0;
    busy_ld    = '0;
    for (int k = 0; k < LD_LAT; k++) begin
      if (pipe[k].v) begin
        busy_ld[pipe[k].dst] = 1'b1;
        if (pipe[k].dst == bus.alu_dst) alu_hit_ld = 1'b1;
      end
    end
  end

  always_comb begin
    ld_hit_q = 1'b0;
    busy_q   = '0;
    for (int k = 0; k < QDEPTH; k++) begin
      if (q_vld[k]) begin
        busy_q[q_ents[k].dst] = 1'b1;
        if (q_ents[k].dst == bus.ld_dst) ld_hit_q = 1'b1;
      end
    end
  end

  // keeps an older result from landing after a younger one
  assign bus.stall = q_full
                   | (bus.ld_valid & ld_hit_q)
                   | (bus.alu_valid & alu_hit_ld);
  assign acc_alu   = bus.alu_valid & ~bus.stall;
  assign acc_ld    = bus.ld_valid & ~bus.stall;

  always_comb begin
    bus.rf_we    = 1'b0;
    bus.rf_ptr_w = '0;
    bus.rf_di    = '0;
    q_pop        = 1'b0;
    q_push       = acc_alu;
    if (ret.v) begin
      bus.rf_we    = 1'b1;
      bus.rf_ptr_w = ret.dst;
      bus.rf_di    = bus.mem_rdata;
    end else if (!q_empty) begin
      bus.rf_we    = 1'b1;
      bus.rf_ptr_w = q_ents[0].dst;
      bus.rf_di    = q_ents[0].data;
      q_pop        = 1'b1;
    end else if (acc_alu) begin
      bus.rf_we    = 1'b1;
      bus.rf_ptr_w = bus.alu_dst;
      bus.rf_di    = bus.alu_data;
      q_push       = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < LD_LAT; k++) pipe[k] <= '0;
    end else begin
      pipe[0] <= '{v: acc_ld, dst: bus.ld_dst};
      for (int k = 1; k < LD_LAT; k++) pipe[k] <= pipe[k-1];
    end
  end

`ifdef RF_WB_FWD_EN
  always_comb begin
    bus.fwd_hit  = 1'b0;
    bus.fwd_data = '0;
    for (int k = 0; k < QDEPTH; k++) begin
      if (q_vld[k] && q_ents[k].dst == bus.fwd_ptr) begin
        bus.fwd_hit  = 1'b1;
        bus.fwd_data = q_ents[k].data;
      end
    end
  end

  // forwarded registers need not block decode
  assign bus.busy = busy_ld;
  wire unused_busy_q = ^busy_q;
`else
  assign bus.busy = busy_ld | busy_q;
`endif

endmodule

// File: tb/tb_rf_writeback.sv
// Self-checking bench for rf_writeback: directed cases plus random traffic
// checked every cycle against a queue-based write-port model.
module tb_rf_writeback;
  import rf_wb_pkg::*;

  localparam int LD_LAT = 2;
  localparam int QDEPTH = 2;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  rf_writeback_if bus ();

  rf_writeback #(
    .LD_LAT(LD_LAT),
    .QDEPTH(QDEPTH)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // reference model: loads as (due cycle, dst), FIFO as a plain queue
  typedef struct {
    int            due;
    logic [AW-1:0] dst;
  } ld_t;

  ld_t     lq [$];
  wb_req_t fq [$];
  int      cyc = 0;

  always @(negedge clk) begin
    logic            e_stall, e_we, hit_a, hit_l, acc_a, direct;
    logic [NREG-1:0] e_busy;
    logic [AW-1:0]   e_ptr;
    logic [DW-1:0]   e_di;
    logic            e_fh;
    logic [DW-1:0]   e_fd;
    if (reset) begin
      lq.delete();
      fq.delete();
      chk("rst_we", bus.rf_we, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_stall", bus.stall, 0);
    end else begin
      hit_a  = 1'b0;
      hit_l  = 1'b0;
      e_busy = '0;
      e_fh   = 1'b0;
      e_fd   = '0;
      foreach (lq[i]) begin
        e_busy[lq[i].dst] = 1'b1;
        if (lq[i].dst == bus.alu_dst) hit_a = 1'b1;
      end
      foreach (fq[i]) begin
`ifndef RF_WB_FWD_EN
        e_busy[fq[i].dst] = 1'b1;
`else
        if (fq[i].dst == bus.fwd_ptr) begin
          e_fh = 1'b1;
          e_fd = fq[i].data;
        end
`endif
        if (fq[i].dst == bus.ld_dst) hit_l = 1'b1;
      end
      e_stall = (fq.size() == QDEPTH) | (bus.ld_valid & hit_l)
              | (bus.alu_valid & hit_a);
      acc_a  = bus.alu_valid & ~e_stall;
      direct = 1'b0;
      e_we   = 1'b0;
      e_ptr  = '0;
      e_di   = '0;
      if (lq.size() > 0 && lq[0].due == cyc) begin
        e_we  = 1'b1;
        e_ptr = lq[0].dst;
        e_di  = bus.mem_rdata;
        void'(lq.pop_front());
      end else if (fq.size() > 0) begin
        e_we  = 1'b1;
        e_ptr = fq[0].dst;
        e_di  = fq[0].data;
        void'(fq.pop_front());
      end else if (acc_a) begin
        e_we   = 1'b1;
        e_ptr  = bus.alu_dst;
        e_di   = bus.alu_data;
        direct = 1'b1;
      end
      chk("stall", bus.stall, e_stall);
      chk("busy", bus.busy, e_busy);
      chk("rf_we", bus.rf_we, e_we);
      chk("rf_ptr_w", bus.rf_ptr_w, e_ptr);
      chk("rf_di", bus.rf_di, e_di);
`ifdef RF_WB_FWD_EN
      chk("fwd_hit", bus.fwd_hit, e_fh);
      chk("fwd_data", bus.fwd_data, e_fd);
`endif
      if (acc_a && !direct)
        fq.push_back('{dst: bus.alu_dst, data: bus.alu_data});
      if (bus.ld_valid && !e_stall)
        lq.push_back('{due: cyc + LD_LAT, dst: bus.ld_dst});
    end
    cyc++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.alu_valid = 1'b0;
    bus.alu_dst   = '0;
    bus.alu_data  = '0;
    bus.ld_valid  = 1'b0;
    bus.ld_dst    = '0;
`ifdef RF_WB_FWD_EN
    bus.fwd_ptr   = '0;
`endif
  endtask

  task automatic alu(input logic [AW-1:0] d, input logic [DW-1:0] v);
    bus.alu_valid = 1'b1;
    bus.alu_dst   = d;
    bus.alu_data  = v;
  endtask

  task automatic ld(input logic [AW-1:0] d);
    bus.ld_valid = 1'b1;
    bus.ld_dst   = d;
  endtask

  localparam logic [NREG-1:0] FQ_B3  =
`ifdef RF_WB_FWD_EN
    4'b0000;
`else
    4'b1000;
`endif
  localparam logic [NREG-1:0] FQ_B23 =
`ifdef RF_WB_FWD_EN
    4'b0000;
`else
    4'b1100;
`endif

  initial begin
    idle();
    bus.mem_rdata = '0;
    repeat (3) step();
    reset = 1'b0;

    // single ALU write goes straight to the port
    step(); alu(1, 8'h5A); #2;
    chk("t1_we", bus.rf_we, 1);
    chk("t1_ptr", bus.rf_ptr_w, 1);
    chk("t1_di", bus.rf_di, 8'h5A);
    step(); idle(); #2;
    chk("t1_busy", bus.busy, 0);

    // load returns LD_LAT cycles later
    step(); ld(2); #2;
    chk("t2_stall", bus.stall, 0);
    step(); idle(); #2;
    chk("t2_busy1", bus.busy, 4'b0100);
    step(); bus.mem_rdata = 8'hC3; #2;
    chk("t2_busy2", bus.busy, 4'b0100);
    chk("t2_we", bus.rf_we, 1);
    chk("t2_ptr", bus.rf_ptr_w, 2);
    chk("t2_di", bus.rf_di, 8'hC3);
    step(); #2;
    chk("t2_busy3", bus.busy, 0);

    // ALU collides with load return and is queued
    step(); ld(0);
    step(); idle();
    step(); alu(3, 8'h11); bus.mem_rdata = 8'h77; #2;
    chk("t3_ptr_ld", bus.rf_ptr_w, 0);
    chk("t3_di_ld", bus.rf_di, 8'h77);
    step(); idle(); #2;
    chk("t3_we_q", bus.rf_we, 1);
    chk("t3_ptr_q", bus.rf_ptr_w, 3);
    chk("t3_di_q", bus.rf_di, 8'h11);
    chk("t3_busy_q", bus.busy, FQ_B3);

    // ALU to a register with a load in flight waits for it
    step(); ld(1);
    step(); idle(); alu(1, 8'h22); #2;
    chk("t4_stall1", bus.stall, 1);
    step(); bus.mem_rdata = 8'h99; #2;
    chk("t4_stall2", bus.stall, 1);
    chk("t4_di_ld", bus.rf_di, 8'h99);
    step(); #2;
    chk("t4_stall3", bus.stall, 0);
    chk("t4_ptr", bus.rf_ptr_w, 1);
    chk("t4_di", bus.rf_di, 8'h22);
    step(); idle();

    // fill the FIFO behind two load returns
    step(); ld(0);
    step(); ld(0);
    step(); idle(); alu(2, 8'hAA);
    step(); alu(3, 8'hBB);
    step(); alu(1, 8'h33); #2;
    chk("t5_stall_full", bus.stall, 1);
    chk("t5_busy", bus.busy, FQ_B23);
    chk("t5_ptr0", bus.rf_ptr_w, 2);
    chk("t5_di0", bus.rf_di, 8'hAA);
    step(); #2;
    chk("t5_stall_drain", bus.stall, 0);
    chk("t5_di1", bus.rf_di, 8'hBB);
    step(); idle(); #2;
    chk("t5_ptr2", bus.rf_ptr_w, 1);
    chk("t5_di2", bus.rf_di, 8'h33);

    // reset with two loads in flight drops them
    step(); ld(1);
    step(); ld(2);
    step(); idle(); bus.mem_rdata = 8'hE1; reset = 1'b1; #2;
    chk("t6_we", bus.rf_we, 0);
    chk("t6_busy", bus.busy, 0);
    chk("t6_stall", bus.stall, 0);
    step(); reset = 1'b0; bus.mem_rdata = 8'h1E; #2;
    chk("t6_we_a", bus.rf_we, 0);
    step(); bus.mem_rdata = 8'hE1; #2;
    chk("t6_we_b", bus.rf_we, 0);

    // random traffic, checked by the model every cycle
    for (int i = 0; i < 800; i++) begin
      step();
      reset = ($urandom_range(0, 199) == 0);
      if (reset) begin
        idle();
      end else begin
        bus.alu_valid = ($urandom_range(0, 99) < 55);
        bus.alu_dst   = AW'($urandom);
        bus.alu_data  = DW'($urandom);
        bus.ld_valid  = ($urandom_range(0, 99) < 40);
        bus.ld_dst    = AW'($urandom);
`ifdef RF_WB_FWD_EN
        bus.fwd_ptr   = AW'($urandom);
`endif
      end
      bus.mem_rdata = DW'($urandom);
    end
    step(); reset = 1'b0; idle();
    repeat (4) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
